ram_sync: RTL and testbench
===========================

# ram_sync

Parametrised single-clock, simple dual-port RAM: one write port and one read port, each with its own address. It is the successor to the fixed 64K x 8 multi-clock RAM. It adds width/depth parameters, an explicit read request with a registered valid strobe, selectable read latency, and a post-reset memory-clear sequencer with a busy flag. It sits between the CPU datapath and the memory map as general-purpose program/data storage.

## Interface
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 16, address bits; depth = 2^ADDR_WIDTH words
- READ_LATENCY, 1, cycles from ReadEnable to ReadValid; legal values 1 or 2
- Clock  input  1  single clock; all logic on rising edge
- Reset  input  1  asynchronous, active-high reset
- AddrIn  input  ADDR_WIDTH  write address
- DataIn  input  DATA_WIDTH  write data
- WriteEnable  input  1  write strobe, sampled each rising edge
- AddrOut  input  ADDR_WIDTH  read address
- ReadEnable  input  1  read request, sampled each rising edge
- DataOut  output  DATA_WIDTH  read data, registered
- ReadValid  output  1  one-cycle strobe: DataOut carries the data for a request
- Busy  output  1  clear sweep in progress; reads and writes are ignored while high

## Operation
- Reset asserted (asynchronous) drives the outputs to these values:
  - DataOut=0 and ReadValid=0.
  - Pipeline valid bits are cleared.
  - Busy=1 and the clear counter is set to 0 when RAM_CLEAR_EN is defined; otherwise Busy=0.
- Reset does not touch memory contents directly.
- State machine (with RAM_CLEAR_EN): ST_CLEAR, ST_READY. Without the macro the block is permanently ST_READY.
- ST_CLEAR:
  - Each cycle writes 0 to mem[ClearAddr] and increments ClearAddr.
  - When ClearAddr = 2^ADDR_WIDTH-1 has been written, the next state is ST_READY and Busy drops.
  - WriteEnable and ReadEnable are ignored. Ignored requests produce no ReadValid and are not queued.
- ST_READY:
  - WriteEnable=1: mem[AddrIn] <= DataIn at the edge.
  - ReadEnable=1: a read of mem[AddrOut] is launched.
- Read-during-write to the same address in the same cycle returns the OLD data (read-before-write, as the predecessor did).
- Reads and writes to different addresses are fully independent. One read and one write can complete every cycle.
- DataOut holds its last value when no read completes. It is never cleared except by Reset.
- ClearAddr counter width is ADDR_WIDTH. The terminal condition is all-ones, not overflow.

## Timing
- READ_LATENCY=1: ReadEnable high at edge N -> DataOut valid and ReadValid=1 after edge N+1, for one cycle unless another read follows.
- READ_LATENCY=2: an extra output register is added. Data and ReadValid appear after edge N+2.
- Back-to-back reads give ReadValid high continuously, with DataOut updating each cycle in request order.
- Clear sweep lasts exactly 2^ADDR_WIDTH cycles from the first rising edge after Reset deasserts.
  - Busy is high for those cycles.
  - The first request accepted is at the first edge where Busy=0.
- Reset asserted mid-clear or mid-read:
  - In-flight reads are dropped, with no ReadValid.
  - The clear restarts from address 0.
  - A write at the same edge as the Reset assertion is not guaranteed.
- A read launched in the last READY cycle before Reset is lost.

## Configuration
- RAM_CLEAR_EN defined:
  - Clear sequencer and state machine are compiled in.
  - After every reset, memory reads as all-zero once Busy falls.
- RAM_CLEAR_EN undefined:
  - No sequencer and no counter; Busy is tied 0.
  - Memory is usable on the first edge after reset, with undefined contents (X in simulation).

## Structure
- Package ram_pkg:
  - State typedef ram_state_t {ST_CLEAR, ST_READY}.
  - Constants RAM_MIN_LATENCY=1 and RAM_MAX_LATENCY=2.
  - Elaboration check: READ_LATENCY must lie in the legal range.
- Sub-module ram_read_pipe: the READ_LATENCY-deep valid/data shift stage, with async Reset on the valid bits.
- The storage array and the clear FSM live in ram_sync.

## Test plan
- RAM_CLEAR_EN, ADDR_WIDTH=4:
  - Release Reset -> Busy=1 for exactly 16 cycles.
  - A ReadEnable during Busy gives no ReadValid.
  - Afterwards, reads of addr 0..15 all return 0x00.
- READ_LATENCY=1: write 0xA5 to 0x0010, then read 0x0010 -> DataOut=0xA5 with ReadValid one cycle after ReadEnable.
- Same-cycle write 0x3C and read to address 0x0020, which holds 0x11 -> DataOut=0x11. The next read returns 0x3C.
- READ_LATENCY=2, reads of 0x0001, 0x0002, 0x0003 on consecutive cycles (holding 0x01, 0x02, 0x03) -> ReadValid high for 3 cycles starting two edges later, with DataOut 0x01, 0x02, 0x03 in order.
- Assert Reset at clear address 7 -> Busy stays 1, and the sweep restarts at 0 and lasts the full 16 cycles after release.
- DATA_WIDTH=16, no RAM_CLEAR_EN:
  - Busy=0 from reset.
  - Write 0xBEEF to the top address (all ones) -> reads back 0xBEEF, with no aliasing at address 0.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared state type and read-latency limits for ram_sync
package ram_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} ram_state_t;
  localparam int RAM_MIN_LATENCY = 1;
  localparam int RAM_MAX_LATENCY = 2;
endpackage

// File: rtl/ram_read_pipe.sv
// ram_read_pipe: READ_LATENCY-deep valid/data shift stage; data only advances with its valid so DataOut holds between reads
module ram_read_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = RAM_MIN_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  logic [READ_LATENCY-1:0] valid_q;
  logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
  // shift valid every cycle; load each data stage only when a read reaches it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end
  assign valid_o = valid_q[READ_LATENCY-1];
  assign data_o  = data_q[READ_LATENCY-1];
endmodule

// File: rtl/ram_sync.sv
// ram_sync: simple dual-port RAM with read-valid pipeline; RAM_CLEAR_EN adds a post-reset zeroing sweep with Busy
module ram_sync
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] AddrIn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] AddrOut,
  input  logic                  ReadEnable,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  ReadValid,
  output logic                  Busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  if (READ_LATENCY < RAM_MIN_LATENCY || READ_LATENCY > RAM_MAX_LATENCY) begin : g_bad_latency
    $error("ram_sync: READ_LATENCY must be 1 or 2");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
`ifdef RAM_CLEAR_EN
  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  // sequencer state; every reset restarts the sweep at address 0
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end
  // one word per cycle; leave the sweep once the all-ones address has been written
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      state_d    = &clr_addr_q ? ST_READY : ST_CLEAR;
    end
  end
  assign clearing = state_q == ST_CLEAR;
  assign clr_addr = clr_addr_q;
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif
  assign Busy    = clearing;
  assign wr_en   = !Reset && (clearing || WriteEnable);
  assign wr_addr = clearing ? clr_addr : AddrIn;
  assign wr_data = clearing ? '0 : DataIn;
  // storage has no reset; the sweep (when compiled in) is what zeroes it
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  // the array is sampled before this edge's write lands, giving read-before-write
  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .valid_i(!clearing && ReadEnable),
    .data_i (mem[AddrOut]),
    .valid_o(ReadValid),
    .data_o (DataOut)
  );
endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: two ram_sync configurations checked every cycle against a queue-based reference model
module tb_ram_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
`ifdef RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  typedef struct {
    int          due;
    logic [15:0] d;
    bit          k;
  } rd_t;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DW    = g ? 16 : 8;
    localparam int AW    = g ? 4 : 6;
    localparam int LAT   = g ? 2 : 1;
    localparam int DEPTH = 2 ** AW;
    logic          rst = 1'b0, we = 1'b0, re = 1'b0;
    logic [AW-1:0] wa = '0, ra = '0;
    logic [DW-1:0] wd = '0;
    logic [DW-1:0] dout;
    logic          rv, busy;
    ram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
      .Clock(clk), .Reset(rst), .AddrIn(wa), .DataIn(wd), .WriteEnable(we),
      .AddrOut(ra), .ReadEnable(re), .DataOut(dout), .ReadValid(rv), .Busy(busy)
    );
    logic [DW-1:0] mm [DEPTH];
    bit            kn [DEPTH];
    int            clr_left = 0;
    int            cyc_n = 0;
    rd_t           q[$];
    logic [DW-1:0] e_dout = '0;
    bit            e_kn = 1'b1;
    bit            e_rv = 1'b0;
    bit            go = 1'b0;
    bit            fin = 1'b0;
    // reference: whole memory zeroed at reset when clearing, requests ignored for DEPTH edges, reads due LAT-1 edges after acceptance
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        e_dout   = '0;
        e_kn     = 1'b1;
        e_rv     = 1'b0;
        clr_left = CLR ? DEPTH : 0;
        if (CLR) for (int i = 0; i < DEPTH; i++) begin
          mm[i] = '0;
          kn[i] = 1'b1;
        end
      end else begin
        cyc_n++;
        e_rv = 1'b0;
        if (clr_left > 0) clr_left--;
        else begin
          if (re) q.push_back('{cyc_n + LAT - 1, 16'(mm[ra]), kn[ra]});
          if (we) begin
            mm[wa] = wd;
            kn[wa] = 1'b1;
          end
        end
        if (q.size() > 0 && q[0].due == cyc_n) begin
          e_rv   = 1'b1;
          e_dout = DW'(q[0].d);
          e_kn   = q[0].k;
          void'(q.pop_front());
        end
      end
    end
    always @(negedge clk) begin
      if (go) begin
        check($sformatf("u%0d busy", g), 32'(busy), 32'(clr_left > 0));
        check($sformatf("u%0d rvalid", g), 32'(rv), 32'(e_rv));
        if (e_kn) check($sformatf("u%0d dout", g), 32'(dout), 32'(e_dout));
      end
    end
    task automatic cyc(input bit w, input int a, input int d, input bit r, input int b);
      we = w;
      wa = AW'(a);
      wd = DW'(d);
      re = r;
      ra = AW'(b);
      @(negedge clk);
    endtask
    task automatic wait_ready(input string tag);
      int n = 0;
      while (busy && n < DEPTH + 8) begin
        cyc(1'b1, $urandom, $urandom, 1'b1, $urandom);
        n++;
      end
      check($sformatf("u%0d %s", g, tag), n, CLR ? DEPTH : 0);
    endtask
    initial begin
      #1 rst = 1'b1;
      go = 1'b1;
      repeat (2) cyc(1'b1, $urandom, $urandom, 1'b1, $urandom);
      rst = 1'b0;
      repeat (7) cyc(1'b1, $urandom, $urandom, 1'b1, $urandom);
      #1 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_ready("busy_len");
      for (int a = 0; a < DEPTH; a++) cyc(1'b0, 0, 0, 1'b1, a);
      cyc(1'b1, 'h10, 'hA5, 1'b0, 0);
      cyc(1'b0, 0, 0, 1'b1, 'h10);
      cyc(1'b0, 0, 0, 1'b0, 0);
      cyc(1'b1, 'h20, 'h11, 1'b0, 0);
      cyc(1'b1, 'h20, 'h3C, 1'b1, 'h20);
      cyc(1'b0, 0, 0, 1'b1, 'h20);
      cyc(1'b0, 0, 0, 1'b0, 0);
      for (int a = 1; a <= 3; a++) cyc(1'b1, a, a, 1'b0, 0);
      for (int a = 1; a <= 3; a++) cyc(1'b0, 0, 0, 1'b1, a);
      cyc(1'b1, DEPTH - 1, 'hBEEF, 1'b0, 0);
      cyc(1'b1, 0, 'h1234, 1'b0, 0);
      cyc(1'b0, 0, 0, 1'b1, DEPTH - 1);
      cyc(1'b0, 0, 0, 1'b1, 0);
      repeat (3) cyc(1'b0, 0, 0, 1'b0, 0);
      repeat (300) cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
      we = 1'b0;
      re = 1'b1;
      ra = AW'(3);
      @(posedge clk);
      #1 rst = 1'b1;
      re = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wait_ready("busy_len_rst");
      for (int a = 0; a < DEPTH; a++) cyc(1'b0, 0, 0, 1'b1, a);
      repeat (4) cyc(1'b0, 0, 0, 1'b0, 0);
      fin = 1'b1;
    end
  end
  initial begin
    bit ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = g_inst[0].fin && g_inst[1].fin;
    end
    check("finish", 32'(ok), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
